// File: rtl/uart_rx_framed_pkg.sv
// Shared UART definitions: receiver state encoding and baud-derived sizing helpers.
package uart_rx_framed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam int FRAME_BITS = 8;

    function automatic int bit_cycles(input int in_freq, input int out_freq);
        return in_freq / out_freq;
    endfunction

    function automatic int cnt_width(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// Byte-level handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if;
    logic [7:0] data;
    logic       ready;
    logic       reset_ready;
    logic       frame_err;
    logic       overrun;

    modport master (output data, ready, frame_err, overrun, input reset_ready);
    modport slave  (input data, ready, frame_err, overrun, output reset_ready);
endinterface

// File: rtl/uart_rx_framed_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value; also usable for push-button inputs.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver: mid-bit sampling, start glitch rejection, framing-error and overrun flags.
module uart_rx_framed
    import uart_rx_framed_pkg::*;
#(
    parameter int IN_FREQ  = 220052,
    parameter int OUT_FREQ = 96
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     rx_i,
    uart_rx_if.master rx_if
);

    localparam int BIT   = bit_cycles(IN_FREQ, OUT_FREQ);
    localparam int HALF  = BIT / 2;
    localparam int CNT_W = cnt_width(BIT);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [2:0]       IDX_LAST = 3'(FRAME_BITS - 1);

    logic rx_s;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ready_d     = ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // Consumer acknowledge; a good-stop completion below overrides it.
        if (rx_if.reset_ready && ready_q) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d      = shift_q;
                        ready_d     = 1'b1;
                        frame_err_d = 1'b0;
                        overrun_d   = ready_q && !rx_if.reset_ready;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // A held-low break must not be re-parsed as a stream of frames.
            ST_WAIT_HIGH: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_if.data      = data_q;
    assign rx_if.ready     = ready_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed at 20 clocks per bit.
module tb_uart_rx_framed;

    logic clk;
    logic reset;
    logic rx_i;
    int   n_checks;
    int   n_fail;
    int   rise;

    uart_rx_if rif ();

    uart_rx_framed #(.IN_FREQ(20), .OUT_FREQ(1)) dut (
        .clk   (clk),
        .reset (reset),
        .rx_i  (rx_i),
        .rx_if (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives up to ncyc cycles of an 8N1 frame starting now; rise_at is the cycle
    // (1 = edge E0) at which ready went 0->1, or -1. rr_at pulses reset_ready (0 = never).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ncyc,
                              input int rr_at, output int rise_at);
        int   cyc;
        logic prev;
        logic v;
        cyc     = 0;
        rise_at = -1;
        prev    = rif.ready;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : ((i == 9) ? stop_bit : b[i-1]);
            rx_i = v;
            for (int j = 0; j < 20; j++) begin
                if (cyc >= ncyc) return;
                tick();
                cyc++;
                if (rr_at != 0 && cyc == rr_at) rif.reset_ready = 1'b1;
                if (rr_at != 0 && cyc == rr_at + 1) rif.reset_ready = 1'b0;
                if (!prev && rif.ready && rise_at < 0) rise_at = cyc;
                prev = rif.ready;
            end
        end
    endtask

    task automatic pulse_rr();
        rif.reset_ready = 1'b1;
        tick();
        rif.reset_ready = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rx_i            = 1'b1;
        reset           = 1'b1;
        rif.reset_ready = 1'b0;
        repeat (3) tick();
        check("rst_data", 32'(rif.data), 32'h00);
        check("rst_ready", 32'(rif.ready), 0);
        check("rst_ferr", 32'(rif.frame_err), 0);
        check("rst_ovr", 32'(rif.overrun), 0);
        reset = 1'b0;
        repeat (5) tick();

        // Good byte
        send_frame(8'hA5, 1'b1, 200, 0, rise);
        check("a5_rise", 32'(rise), 32'd193);
        check("a5_data", 32'(rif.data), 32'hA5);
        check("a5_ferr", 32'(rif.frame_err), 0);
        check("a5_ovr", 32'(rif.overrun), 0);
        pulse_rr();
        check("a5_rr_ready", 32'(rif.ready), 0);
        repeat (10) tick();

        // Start glitch
        rx_i = 1'b0;
        repeat (5) tick();
        rx_i = 1'b1;
        repeat (30) tick();
        check("gl_ready", 32'(rif.ready), 0);
        check("gl_ferr", 32'(rif.frame_err), 0);
        check("gl_ovr", 32'(rif.overrun), 0);
        check("gl_data", 32'(rif.data), 32'hA5);
        send_frame(8'h3C, 1'b1, 200, 0, rise);
        check("3c_rise", 32'(rise), 32'd193);
        check("3c_data", 32'(rif.data), 32'h3C);
        pulse_rr();
        repeat (10) tick();

        // Framing error followed by a held-low break
        send_frame(8'h55, 1'b0, 200, 0, rise);
        check("fe_ferr", 32'(rif.frame_err), 1);
        check("fe_data", 32'(rif.data), 32'h3C);
        check("fe_ready", 32'(rif.ready), 0);
        check("fe_rise", 32'(rise), 32'hFFFF_FFFF);
        repeat (60) tick();
        check("brk_ready", 32'(rif.ready), 0);
        check("brk_data", 32'(rif.data), 32'h3C);
        rx_i = 1'b1;
        repeat (20) tick();
        check("brk_ferr", 32'(rif.frame_err), 1);
        send_frame(8'h81, 1'b1, 200, 0, rise);
        check("81_rise", 32'(rise), 32'd193);
        check("81_data", 32'(rif.data), 32'h81);
        check("81_ferr", 32'(rif.frame_err), 0);
        pulse_rr();
        repeat (10) tick();

        // Overrun, frames back to back
        send_frame(8'h11, 1'b1, 200, 0, rise);
        check("11_ready", 32'(rif.ready), 1);
        check("11_ovr", 32'(rif.overrun), 0);
        send_frame(8'h22, 1'b1, 200, 0, rise);
        check("ov_data", 32'(rif.data), 32'h22);
        check("ov_ready", 32'(rif.ready), 1);
        check("ov_ovr", 32'(rif.overrun), 1);
        pulse_rr();
        check("ov_rr_ready", 32'(rif.ready), 0);
        check("ov_rr_ovr", 32'(rif.overrun), 0);
        repeat (10) tick();

        // reset_ready coinciding with completion
        send_frame(8'h11, 1'b1, 200, 0, rise);
        send_frame(8'h22, 1'b1, 200, 192, rise);
        check("sim_ready", 32'(rif.ready), 1);
        check("sim_ovr", 32'(rif.overrun), 0);
        check("sim_data", 32'(rif.data), 32'h22);

        // Reset during data bit 4
        send_frame(8'hF0, 1'b1, 110, 0, rise);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_data", 32'(rif.data), 32'h00);
        check("mid_ready", 32'(rif.ready), 0);
        check("mid_ferr", 32'(rif.frame_err), 0);
        check("mid_ovr", 32'(rif.overrun), 0);
        rx_i = 1'b1;
        repeat (120) tick();
        check("mid_idle_ready", 32'(rif.ready), 0);
        send_frame(8'h0F, 1'b1, 200, 0, rise);
        check("0f_rise", 32'(rise), 32'd193);
        check("0f_data", 32'(rif.data), 32'h0F);
        check("0f_ferr", 32'(rif.frame_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
